scratch_mem_arbiter: RTL and testbench
======================================

# scratch_mem_arbiter

Round-robin arbiter and command pipeline for the shared 2048×32 scratch memory used by the G.729 encoder sub-blocks (perceptual-variable FSM, LSP interpolation, Levinson-Durbin, and similar). It grants one requester per cycle, supports locked multi-cycle ownership for read-modify-write sequences, and registers the winning command onto the single memory port. A test-mux override gives the bench exclusive access to the memory for loading inputs and checking outputs.

## Interface
- NREQ, 4, number of FSM requesters (index 0 = highest priority after reset)
- ADDR_W, 11, scratch memory address width
- DATA_W, 32, scratch memory data width
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  NREQ  per-requester access request, level
- lock  in  NREQ  per-requester hold-ownership flag, sampled only while that requester is granted
- reqWrite  in  NREQ  per-requester write enable (1 = write, 0 = read)
- reqAddr  in  NREQ*ADDR_W  packed addresses, requester k at bits [k*ADDR_W +: ADDR_W]
- reqData  in  NREQ*DATA_W  packed write data, same packing
- gnt  out  NREQ  one-hot grant, combinational, valid in the cycle the command is accepted
- rvalid  out  NREQ  one-hot read-data-valid strobe
- rdata  out  DATA_W  read data, broadcast to all requesters, qualified by rvalid
- testMuxSel  in  1  1 = test port owns memory; no FSM grants
- testMemWrite  in  1  test write enable
- testWriteAddr  in  ADDR_W  test write address
- testReadAddr  in  ADDR_W  test read address
- testMemOut  in  DATA_W  test write data
- memAddr  out  ADDR_W  registered memory address
- memWrite  out  1  registered memory write enable
- memOut  out  DATA_W  registered memory write data
- memIn  in  DATA_W  memory read data, valid one cycle after memAddr (synchronous BRAM)

## Operation
- States: ARB (free arbitration), LOCKED (owner held), TEST (test override).
- ARB: if any req, gnt = first set bit of req searching from pointer ptr upward, wrapping modulo NREQ. Winner's command registered to memory port. ptr <= winner+1 (mod NREQ). If lock[winner] is high, go to LOCKED with owner = winner.
- LOCKED: gnt = owner only while req[owner] is high; other requests ignored. Exit to ARB when req[owner] or lock[owner] is low in a cycle; if req[owner] is still high in that cycle, that last access is granted. ptr unchanged while locked.
- TEST (entered whenever testMuxSel = 1, from any state, at the next edge): gnt = 0. memAddr <= testMemWrite ? testWriteAddr : testReadAddr; memWrite <= testMemWrite; memOut <= testMemOut. Any lock is dropped. On testMuxSel = 0, return to ARB with ptr preserved.
- While testMuxSel = 1 combinationally, gnt = 0 in that same cycle (override is immediate for grants).
- No request and not TEST: memWrite <= 0; memAddr/memOut hold.
- Read tracking: a 2-stage shift of {valid, owner index}. A granted read sets rvalid[owner] two edges later with rdata = memIn. Test reads generate no rvalid; the bench samples memIn directly.
- In-flight reads complete after a transition into TEST.

## Timing
- Cycle t: req[k] high and gnt[k] high. Edge t+1: memAddr/memWrite/memOut updated. Edge t+2: memIn valid; rvalid[k] high during cycle t+2.
- Write issued in cycle t is visible to a read that is granted in cycle t+1 (BRAM is write-first).
- Back-to-back grants: one command per cycle, zero bubbles.
- Reset values: gnt = 0, rvalid = 0, rdata = 0, memAddr = 0, memWrite = 0, memOut = 0, ptr = 0, state = ARB, read pipe empty.
- Reset mid-transaction: pending rvalid is discarded; requesters must re-issue.

## Structure
- Shared package/include (paramList): ARB/LOCKED/TEST state encodings, default ADDR_W/DATA_W, and memory region base constants (PERC_VAR_GAMMA1, INTERPOLATION_LSF_INT, etc.).
- Sub-module rr_priority_pick: combinational one-hot pick over a request vector starting from ptr with wrap. The rest (state register, command register, read pipe) sits in the top module.

## Test plan
- Reset defaults: assert reset mid-clock (asynchronous) -> all outputs 0 immediately, and ptr = 0.
- Round-robin: req = 4'b1111 held for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, and repeat; with req = 4'b1010 starting at ptr = 0 -> 0010, 1000, 0010.
- Lock: requester 2 wins with lock = 1 for 5 cycles while req = 4'b1111 -> gnt = 0100 for all 5 cycles; after lock drops, the next grant is 1000.
- Read latency: requester 1 writes 0x0000_1234 to addr 0x1A0, then reads 0x1A0 the next cycle -> rvalid = 0010 exactly 2 cycles after the read grant, and rdata = 0x0000_1234.
- Test override: testMuxSel = 1 during a lock with req = 4'b0001 -> gnt = 0 that cycle; test write of 0x7FFF to 0x3C2, then read 0x3C2 -> memIn = 0x7FFF after two edges; on release, ARB resumes with no lock.
- Simultaneous: testMuxSel rises in the same cycle as an FSM read grant that is already in flight -> the FSM rvalid is still delivered 2 cycles after grant, and the test command follows in the next memory slot.

Source files
------------

// File: rtl/scratch_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// scratch_mem_arbiter_pkg
//   Shared definitions for the scratch memory arbiter and its users:
//   arbiter state encodings, default geometry of the 2048x32 scratch memory,
//   and base addresses of the memory regions owned by the encoder sub-blocks.
// ---------------------------------------------------------------------------
package scratch_mem_arbiter_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ARB    = 2'd0,  // free round-robin arbitration
        LOCKED = 2'd1,  // one requester holds the port for an RMW sequence
        TEST   = 2'd2   // test port owns the memory
    } arbState_t;

    // Region bases inside the scratch memory.
    localparam logic [ADDR_W_DEF-1:0] PERC_VAR_GAMMA1       = 11'h000;
    localparam logic [ADDR_W_DEF-1:0] PERC_VAR_GAMMA2       = 11'h010;
    localparam logic [ADDR_W_DEF-1:0] INTERPOLATION_LSF_INT = 11'h040;
    localparam logic [ADDR_W_DEF-1:0] INTERPOLATION_LSF_NEW = 11'h050;
    localparam logic [ADDR_W_DEF-1:0] LEVINSON_A            = 11'h100;
    localparam logic [ADDR_W_DEF-1:0] LEVINSON_RC           = 11'h120;

endpackage

// File: rtl/scratch_mem_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
//   Combinational round-robin pick: returns the first set bit of req found
//   when searching upward from ptr, wrapping modulo N.
// Ports:
//   req  - request vector
//   ptr  - index with highest priority this cycle
//   gnt  - one-hot winner (all zero when no request)
//   idx  - binary index of the winner
//   any  - at least one request present
// N must be at least 2.
// ---------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int          k;
    logic [IW-1:0] kIdx;

    // Walk offsets from farthest to nearest so the nearest hit to ptr is the
    // last assignment and therefore wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        k    = 0;
        kIdx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k    = (int'(ptr) + i) % N;
            kIdx = IW'(k);
            if (req[kIdx]) begin
                gnt       = '0;
                gnt[kIdx] = 1'b1;
                idx       = kIdx;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scratch_mem_arbiter.sv
// ---------------------------------------------------------------------------
// scratch_mem_arbiter
//   Round-robin arbiter and registered command port for the shared scratch
//   memory. One command per cycle, locked ownership for RMW sequences, and a
//   test-mux override that gives the test port exclusive access.
//
// Handshake: req[k] is a level request carrying reqWrite/reqAddr/reqData.
//   gnt[k] (combinational) high in a cycle means the command presented in
//   that same cycle is accepted; the requester may change its command at the
//   next edge. A granted read returns rdata qualified by rvalid[k] two edges
//   after the grant cycle. There is no backpressure on rvalid.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   req/lock/reqWrite   - per-requester request, hold-ownership, write flag
//   reqAddr/reqData     - packed per-requester address / write data
//   gnt, rvalid, rdata  - grant, read-valid strobe, broadcast read data
//   test*               - test port (testMuxSel = 1 takes the memory)
//   memAddr/memWrite/memOut - registered memory command
//   memIn               - synchronous memory read data
//   dbgState, dbgPtr    - arbiter state and round-robin pointer
// ---------------------------------------------------------------------------
module scratch_mem_arbiter
    import scratch_mem_arbiter_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        lock,
    input  logic [NREQ-1:0]        reqWrite,
    input  logic [NREQ*ADDR_W-1:0] reqAddr,
    input  logic [NREQ*DATA_W-1:0] reqData,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DATA_W-1:0]      rdata,
    input  logic                   testMuxSel,
    input  logic                   testMemWrite,
    input  logic [ADDR_W-1:0]      testWriteAddr,
    input  logic [ADDR_W-1:0]      testReadAddr,
    input  logic [DATA_W-1:0]      testMemOut,
    output logic [ADDR_W-1:0]      memAddr,
    output logic                   memWrite,
    output logic [DATA_W-1:0]      memOut,
    input  logic [DATA_W-1:0]      memIn,
    output arbState_t              dbgState,
    output logic [IDX_W-1:0]       dbgPtr
);

    arbState_t        state, nextState;
    logic [IDX_W-1:0] ptr, nextPtr;
    logic [IDX_W-1:0] owner, nextOwner;

    logic [NREQ-1:0]  pickGnt;
    logic [IDX_W-1:0] pickIdx;
    logic             pickAny;

    logic             issue;
    logic [IDX_W-1:0] issueIdx;

    // Read tracking pipe: stage 0 covers the edge that registers the
    // command, stage 1 the edge at which memIn becomes valid.
    logic             rdValid0, rdValid1;
    logic [IDX_W-1:0] rdIdx0, rdIdx1;

    rr_priority_pick #(
        .N  (NREQ),
        .IW (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pickGnt),
        .idx (pickIdx),
        .any (pickAny)
    );

    // ------------------------------------------------------------------
    // Next-state, grant and issue decision
    // ------------------------------------------------------------------
    always_comb begin
        nextState = state;
        nextPtr   = ptr;
        nextOwner = owner;
        gnt       = '0;
        issue     = 1'b0;
        issueIdx  = '0;

        if (reset) begin
            // Grants are suppressed while reset is held.
            nextState = ARB;
        end else if (testMuxSel) begin
            // Override is immediate for grants; the state follows at the edge.
            nextState = TEST;
        end else begin
            unique case (state)
                LOCKED: begin
                    if (req[owner]) begin
                        gnt[owner] = 1'b1;
                        issue      = 1'b1;
                        issueIdx   = owner;
                    end
                    if (!req[owner] || !lock[owner]) begin
                        nextState = ARB;
                    end
                end
                // Leaving TEST behaves as ARB in the first released cycle,
                // so no slot is lost on the way back.
                default: begin
                    nextState = ARB;
                    if (pickAny) begin
                        gnt      = pickGnt;
                        issue    = 1'b1;
                        issueIdx = pickIdx;
                        nextPtr  = (pickIdx == IDX_W'(NREQ - 1)) ? '0
                                                                 : pickIdx + IDX_W'(1);
                        if (lock[pickIdx]) begin
                            nextState = LOCKED;
                            nextOwner = pickIdx;
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, pointer and owner registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= nextState;
            ptr   <= nextPtr;
            owner <= nextOwner;
        end
    end

    // ------------------------------------------------------------------
    // Memory command register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memAddr  <= '0;
            memWrite <= 1'b0;
            memOut   <= '0;
        end else if (testMuxSel) begin
            memAddr  <= testMemWrite ? testWriteAddr : testReadAddr;
            memWrite <= testMemWrite;
            memOut   <= testMemOut;
        end else if (issue) begin
            memAddr  <= reqAddr[int'(issueIdx)*ADDR_W +: ADDR_W];
            memWrite <= reqWrite[issueIdx];
            memOut   <= reqData[int'(issueIdx)*DATA_W +: DATA_W];
        end else begin
            memWrite <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read tracking; in-flight reads keep draining through a TEST entry.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdValid0 <= 1'b0;
            rdValid1 <= 1'b0;
            rdIdx0   <= '0;
            rdIdx1   <= '0;
        end else begin
            rdValid0 <= issue && !reqWrite[issueIdx];
            rdIdx0   <= issueIdx;
            rdValid1 <= rdValid0;
            rdIdx1   <= rdIdx0;
        end
    end

    assign rvalid   = rdValid1 ? (NREQ'(1) << rdIdx1) : '0;
    assign rdata    = rdValid1 ? memIn : '0;

    assign dbgState = state;
    assign dbgPtr   = ptr;

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_scratch_mem_arbiter
//   Directed bench for scratch_mem_arbiter with a write-first synchronous
//   2048x32 memory model attached to the command port.
// ---------------------------------------------------------------------------
module tb_scratch_mem_arbiter;
    import scratch_mem_arbiter_pkg::*;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic                   clk;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        lock;
    logic [NREQ-1:0]        reqWrite;
    logic [NREQ*ADDR_W-1:0] reqAddr;
    logic [NREQ*DATA_W-1:0] reqData;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;
    logic                   testMuxSel;
    logic                   testMemWrite;
    logic [ADDR_W-1:0]      testWriteAddr;
    logic [ADDR_W-1:0]      testReadAddr;
    logic [DATA_W-1:0]      testMemOut;
    logic [ADDR_W-1:0]      memAddr;
    logic                   memWrite;
    logic [DATA_W-1:0]      memOut;
    logic [DATA_W-1:0]      memIn;
    arbState_t              dbgState;
    logic [1:0]             dbgPtr;

    int nChecks = 0;
    int nPass   = 0;

    scratch_mem_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .lock          (lock),
        .reqWrite      (reqWrite),
        .reqAddr       (reqAddr),
        .reqData       (reqData),
        .gnt           (gnt),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .testMuxSel    (testMuxSel),
        .testMemWrite  (testMemWrite),
        .testWriteAddr (testWriteAddr),
        .testReadAddr  (testReadAddr),
        .testMemOut    (testMemOut),
        .memAddr       (memAddr),
        .memWrite      (memWrite),
        .memOut        (memOut),
        .memIn         (memIn),
        .dbgState      (dbgState),
        .dbgPtr        (dbgPtr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model (write-first BRAM) ----------------
    logic [DATA_W-1:0] mem [0:2047];

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        memIn = '0;
    end

    always @(posedge clk) begin
        if (memWrite) begin
            mem[memAddr] <= memOut;
            memIn        <= memOut;
        end else begin
            memIn <= mem[memAddr];
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            nPass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setCmd(input int k, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        reqWrite[k]               = wr;
        reqAddr[k*ADDR_W +: ADDR_W] = a;
        reqData[k*DATA_W +: DATA_W] = d;
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] rrPartial [3];

    initial begin
        reset         = 1'b1;
        req           = '0;
        lock          = '0;
        reqWrite      = '0;
        reqAddr       = '0;
        reqData       = '0;
        testMuxSel    = 1'b0;
        testMemWrite  = 1'b0;
        testWriteAddr = '0;
        testReadAddr  = '0;
        testMemOut    = '0;
        rrPartial     = '{4'b0010, 4'b1000, 4'b0010};

        tick();
        tick();
        reset = 1'b0;

        // ---- asynchronous reset mid-clock ----
        req = 4'b0001;
        setCmd(0, 1'b1, 11'h055, 32'h0000_ABCD);
        @(negedge clk);
        check("pre_rst_gnt", 64'(gnt), 64'(4'b0001));
        tick();
        req      = '0;
        reqWrite = '0;
        check("pre_rst_addr", 64'(memAddr), 64'(11'h055));
        #2;
        reset = 1'b1;
        #1;
        check("rst_gnt",      64'(gnt),      64'(0));
        check("rst_rvalid",   64'(rvalid),   64'(0));
        check("rst_rdata",    64'(rdata),    64'(0));
        check("rst_memAddr",  64'(memAddr),  64'(0));
        check("rst_memWrite", 64'(memWrite), 64'(0));
        check("rst_memOut",   64'(memOut),   64'(0));
        check("rst_ptr",      64'(dbgPtr),   64'(0));
        check("rst_state",    64'(dbgState), 64'(ARB));
        tick();
        tick();
        reset = 1'b0;

        // ---- round robin, all requesting ----
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_all", 64'(gnt), 64'(1) << (i % 4));
            tick();
        end
        req = '0;
        @(negedge clk);
        check("rr_idle_gnt", 64'(gnt), 64'(0));
        tick();

        // ---- round robin, sparse request ----
        req = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rr_1010", 64'(gnt), 64'(rrPartial[i]));
            tick();
        end
        req = '0;
        @(negedge clk);
        check("rr_ptr", 64'(dbgPtr), 64'(2));
        tick();

        // ---- locked ownership by requester 2 ----
        req  = 4'b1111;
        lock = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lock_gnt", 64'(gnt), 64'(4'b0100));
            if (i > 0) check("lock_state", 64'(dbgState), 64'(LOCKED));
            tick();
        end
        lock = '0;
        @(negedge clk);
        check("lock_last", 64'(gnt), 64'(4'b0100));
        tick();
        @(negedge clk);
        check("after_lock_gnt",   64'(gnt),      64'(4'b1000));
        check("after_lock_state", 64'(dbgState), 64'(ARB));
        tick();
        req = '0;
        @(negedge clk);
        check("idle_memWrite", 64'(memWrite), 64'(0));
        tick();

        // ---- write then read by requester 1 ----
        req = 4'b0010;
        setCmd(1, 1'b1, 11'h1A0, 32'h0000_1234);
        @(negedge clk);
        check("wr_gnt", 64'(gnt), 64'(4'b0010));
        tick();
        reqWrite[1] = 1'b0;
        @(negedge clk);
        check("rd_gnt",      64'(gnt),      64'(4'b0010));
        check("wr_memWrite", 64'(memWrite), 64'(1));
        check("wr_memAddr",  64'(memAddr),  64'(11'h1A0));
        check("wr_memOut",   64'(memOut),   64'(32'h0000_1234));
        tick();
        req = '0;
        @(negedge clk);
        check("rd_rvalid_early", 64'(rvalid),   64'(0));
        check("rd_memWrite",     64'(memWrite), 64'(0));
        check("rd_memAddr",      64'(memAddr),  64'(11'h1A0));
        tick();
        @(negedge clk);
        check("rd_rvalid", 64'(rvalid), 64'(4'b0010));
        check("rd_rdata",  64'(rdata),  64'(32'h0000_1234));
        tick();

        // ---- test override during a lock ----
        req  = 4'b0001;
        lock = 4'b0001;
        setCmd(0, 1'b0, 11'h010, 32'h0);
        @(negedge clk);
        check("tlock_gnt", 64'(gnt), 64'(4'b0001));
        tick();
        testMuxSel    = 1'b1;
        testMemWrite  = 1'b1;
        testWriteAddr = 11'h3C2;
        testMemOut    = 32'h0000_7FFF;
        @(negedge clk);
        check("tsel_gnt",   64'(gnt),      64'(0));
        check("tsel_state", 64'(dbgState), 64'(LOCKED));
        tick();
        testMemWrite = 1'b0;
        testReadAddr = 11'h3C2;
        @(negedge clk);
        check("test_gnt",      64'(gnt),      64'(0));
        check("test_state",    64'(dbgState), 64'(TEST));
        check("test_memAddr",  64'(memAddr),  64'(11'h3C2));
        check("test_memWrite", 64'(memWrite), 64'(1));
        check("test_memOut",   64'(memOut),   64'(32'h0000_7FFF));
        check("test_inflight", 64'(rvalid),   64'(4'b0001));
        tick();
        @(negedge clk);
        check("test_rd_memWrite", 64'(memWrite), 64'(0));
        check("test_rd_memAddr",  64'(memAddr),  64'(11'h3C2));
        tick();
        testMuxSel = 1'b0;
        lock       = '0;
        req        = 4'b0011;
        @(negedge clk);
        check("test_memIn",   64'(memIn),    64'(32'h0000_7FFF));
        check("test_norv",    64'(rvalid),   64'(0));
        check("release_gnt",  64'(gnt),      64'(4'b0010));
        tick();
        @(negedge clk);
        check("release_state", 64'(dbgState), 64'(ARB));
        check("release_gnt2",  64'(gnt),      64'(4'b0001));
        tick();
        req = '0;

        // ---- test select rising behind an in-flight FSM read ----
        req = 4'b1000;
        setCmd(3, 1'b0, 11'h1A0, 32'h0);
        @(negedge clk);
        check("sim_gnt", 64'(gnt), 64'(4'b1000));
        tick();
        testMuxSel   = 1'b1;
        testMemWrite = 1'b0;
        testReadAddr = 11'h3C2;
        @(negedge clk);
        check("sim_tgnt",    64'(gnt),     64'(0));
        check("sim_memAddr", 64'(memAddr), 64'(11'h1A0));
        tick();
        testMuxSel = 1'b0;
        req        = '0;
        @(negedge clk);
        check("sim_rvalid",   64'(rvalid),   64'(4'b1000));
        check("sim_rdata",    64'(rdata),    64'(32'h0000_1234));
        check("sim_tmemAddr", 64'(memAddr),  64'(11'h3C2));
        check("sim_tmemWr",   64'(memWrite), 64'(0));
        tick();
        @(negedge clk);
        check("sim_memIn",  64'(memIn),  64'(32'h0000_7FFF));
        check("sim_norv",   64'(rvalid), 64'(0));
        tick();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
